// File: rtl/fp_arith_pkg.sv
// rtl/fp_arith_pkg.sv - shared fp32 type, quiet-NaN constant and arbiter state encoding
package fp_arith_pkg;

  typedef logic [31:0] fp32_t;

  localparam fp32_t FP32_QNAN = 32'h7FC00000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - combinational round-robin pick: first set request at or above ptr_i, wrapping
module rr_priority_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] idx_o,
  output logic                       any_o
);

  localparam int IW = $clog2(NUM_REQ);

  int slot;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    slot  = 0;
    // Scan farthest-first so the slot nearest ptr_i is the last writer and wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      slot = (int'(ptr_i) + k) % NUM_REQ;
      if (req_i[slot]) begin
        idx_o = IW'(slot);
        any_o = 1'b1;
      end
    end
    if (any_o) gnt_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/fp_mult_arbiter.sv
// rtl/fp_mult_arbiter.sv - round-robin sharing of one multi-cycle fp32 multiplier among NUM_REQ clients
// Optional WAIT watchdog with quiet-NaN substitute result: FP_ARB_TIMEOUT_EN.
module fp_mult_arbiter
  import fp_arith_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [31:0]            rsp_data,
  output logic                   rsp_err,
  output logic                   busy,
  output logic                   mult_input_valid,
  output logic [31:0]            mult_in_a,
  output logic [31:0]            mult_in_b,
  input  logic [31:0]            mult_data_out,
  input  logic                   mult_output_valid
);

  localparam int IW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_bad_param
    $error("fp_mult_arbiter: NUM_REQ must be 2..8 and TIMEOUT >= 1");
  end

  arb_state_t        state_q, state_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]     gid_q, gid_d;
  fp32_t             a_q, a_d, b_q, b_d, res_q, res_d;
  logic              err_q, err_d;
  logic              tmo_hit;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;

  rr_priority_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

`ifdef FP_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;

  always_comb begin
    tmo_d = tmo_q;
    if (state_q == ISSUE)     tmo_d = '0;
    else if (state_q == WAIT) tmo_d = tmo_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tmo_q <= '0;
    else          tmo_q <= tmo_d;
  end

  // tmo_q counts completed WAIT cycles, so this fires on the TIMEOUT-th one.
  assign tmo_hit = (state_q == WAIT) && (tmo_q == TW'(TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gid_d    = gid_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          gid_d   = pick_idx;
          a_d     = req_a[32*int'(pick_idx) +: 32];
          b_d     = req_b[32*int'(pick_idx) +: 32];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        err_d   = 1'b0;
        state_d = WAIT;
      end
      WAIT: begin
        if (mult_output_valid) begin
          res_d   = mult_data_out;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (tmo_hit) begin
          res_d   = FP32_QNAN;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        rr_ptr_d = (gid_q == IW'(NUM_REQ - 1)) ? '0 : gid_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      gid_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gid_q    <= gid_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      err_q    <= err_d;
    end
  end

  assign req_ready        = (state_q == IDLE) ? pick_gnt : '0;
  assign busy             = (state_q != IDLE);
  assign mult_input_valid = (state_q == ISSUE);
  assign mult_in_a        = a_q;
  assign mult_in_b        = b_q;
  assign rsp_valid        = (state_q == RESP) ? (NUM_REQ'(1) << gid_q) : '0;
  assign rsp_data         = res_q;
  assign rsp_err          = (state_q == RESP) && err_q;

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// tb/tb_fp_mult_arbiter.sv - scoreboard bench for fp_mult_arbiter with a behavioural multiplier stub
`timescale 1ns/1ps
module tb_fp_mult_arbiter;

  localparam int N = 4;
`ifdef FP_ARB_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 64;
`endif

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   req_valid, req_ready, rsp_valid;
  logic [32*N-1:0] req_a, req_b;
  logic [31:0]    rsp_data, mult_in_a, mult_in_b, mult_data_out;
  logic           rsp_err, busy, mult_input_valid, mult_output_valid;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fp_mult_arbiter #(.NUM_REQ(N), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .mult_input_valid(mult_input_valid), .mult_in_a(mult_in_a), .mult_in_b(mult_in_b),
    .mult_data_out(mult_data_out), .mult_output_valid(mult_output_valid)
  );

  // Truncating fp32 multiply for normal operands whose product stays normal.
  function automatic logic [31:0] fp_mul_ref(logic [31:0] a, logic [31:0] b);
    logic [47:0] m;
    int e;
    m = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (m[47]) begin e = e + 1; m = m >> 1; end
    fp_mul_ref = {a[31] ^ b[31], e[7:0], m[45:23]};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0] ex;
    logic [22:0] mn;
    ex = 8'($urandom_range(100, 150));
    mn = 23'($urandom);
    rand_fp = {1'($urandom_range(0, 1)), ex, mn};
  endfunction

  function automatic int rr_pick(logic [N-1:0] v, int ptr);
    for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Multiplier stub: fixed latency per op, optional junk pulses while no op is pending.
  int          mult_lat = 2;
  bit          mult_dead = 1'b0;
  bit          mult_noise = 1'b0;
  int          stub_cnt;
  bit          stub_pend;
  logic [31:0] stub_a, stub_b;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stub_pend <= 1'b0; stub_cnt <= 0; stub_a <= '0; stub_b <= '0;
      mult_output_valid <= 1'b0; mult_data_out <= '0;
    end else begin
      mult_output_valid <= 1'b0;
      if (mult_input_valid) begin
        stub_pend <= !mult_dead; stub_cnt <= mult_lat - 1;
        stub_a <= mult_in_a; stub_b <= mult_in_b;
      end else if (stub_pend) begin
        if (stub_cnt == 0) begin
          mult_output_valid <= 1'b1;
          mult_data_out <= fp_mul_ref(stub_a, stub_b);
          stub_pend <= 1'b0;
        end else stub_cnt <= stub_cnt - 1;
      end else if (mult_noise && $urandom_range(0, 3) == 0) begin
        mult_output_valid <= 1'b1;
        mult_data_out <= $urandom;
      end
    end
  end

  typedef struct {
    int          id;
    logic [31:0] data;
    logic        err;
    int          lat;
    int          t_acc;
  } exp_t;
  exp_t sb[$];

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_n && rsp_valid != '0) begin
      if (sb.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL stray_rsp: got rsp_valid %b expected none (cycle %0d)", rsp_valid, cyc);
      end else begin
        e = sb.pop_front();
        check("rsp_valid", 32'(rsp_valid), 32'(1) << e.id);
        check("rsp_data", rsp_data, e.data);
        check("rsp_err", 32'(rsp_err), 32'(e.err));
        check("latency", cyc - e.t_acc, e.lat);
      end
    end
  end

  int          rr_model = 0;
  bit          outstanding = 1'b0;
  bit          issue_due = 1'b0;
  logic [31:0] iss_a, iss_b;
  int          remain[N];
  logic [31:0] opa[N], opb[N];
  bit          fixed[N];
  int          grants[$];
  bit          rand_mode = 1'b0;
  bit          want_set = 1'b0;
  logic [31:0] want_data = '0;
  int          force_lat = 0;

  task automatic set_req(int i, logic [31:0] a, logic [31:0] b, int n, bit fx);
    opa[i] = a; opb[i] = b; remain[i] = n; fixed[i] = fx;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_valid[i] = 1'b1;
  endtask

  task automatic cycle_step();
    int g;
    logic [N-1:0] acc;
    logic [31:0] d;
    acc = '0;
    @(negedge clk);
    check("busy", 32'(busy), 32'(outstanding));
    if (issue_due) begin
      check("mult_input_valid", 32'(mult_input_valid), 32'd1);
      check("mult_in_a", mult_in_a, iss_a);
      check("mult_in_b", mult_in_b, iss_b);
      issue_due = 1'b0;
    end else check("mult_input_valid_idle", 32'(mult_input_valid), 32'd0);
    if (outstanding) begin
      check("req_ready_busy", 32'(req_ready), 32'd0);
      if (rsp_valid != '0) outstanding = 1'b0;
    end else begin
      g = rr_pick(req_valid, rr_model);
      check("req_ready", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
      if (g >= 0) begin
        outstanding = 1'b1; issue_due = 1'b1;
        iss_a = opa[g]; iss_b = opb[g];
        rr_model = (g + 1) % N;
        grants.push_back(g);
        mult_lat = (force_lat > 0) ? force_lat : $urandom_range(1, 5);
        d = mult_dead ? 32'h7FC00000 : (want_set ? want_data : fp_mul_ref(opa[g], opb[g]));
        sb.push_back('{g, d, mult_dead, mult_dead ? TMO + 2 : mult_lat + 3, cyc});
        acc[g] = 1'b1;
      end
    end
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        remain[i]--;
        if (remain[i] <= 0) req_valid[i] = 1'b0;
        else if (!fixed[i]) set_req(i, rand_fp(), rand_fp(), remain[i], 1'b0);
      end else if (rand_mode) begin
        if (!req_valid[i] && $urandom_range(0, 3) == 0)
          set_req(i, rand_fp(), rand_fp(), $urandom_range(1, 3), 1'b0);
        else if (req_valid[i] && $urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0; remain[i] = 0;
        end
      end
    end
  endtask

  task automatic run_until_idle(int max_cyc);
    int n;
    n = 0;
    while ((req_valid != '0 || outstanding || sb.size() != 0) && n < max_cyc) begin
      cycle_step();
      n++;
    end
    compared++;
    if (n >= max_cyc) begin
      mismatched++;
      $display("FAIL drain_timeout: still active after %0d cycles, required idle", n);
    end
  endtask

  // seq holds expected grant indices, one per nibble, first grant in the low nibble.
  task automatic check_grants(string name, logic [31:0] seq, int n);
    check({name, "_count"}, grants.size(), n);
    for (int i = 0; i < n && i < grants.size(); i++) check(name, grants[i], 32'(seq[4*i +: 4]));
    grants.delete();
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_data"}, rsp_data, 32'd0);
    check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_mult_iv"}, 32'(mult_input_valid), 32'd0);
    check({tag, "_mult_in_a"}, mult_in_a, 32'd0);
    check({tag, "_mult_in_b"}, mult_in_b, 32'd0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stimulus
    int n;
    req_valid = '0; req_a = '0; req_b = '0;
    for (int i = 0; i < N; i++) begin remain[i] = 0; opa[i] = '0; opb[i] = '0; fixed[i] = 1'b0; end
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset_n = 1'b1;

    // Single op on requester 0: 2.0 * 3.0.
    want_set = 1'b1; want_data = 32'h40C00000;
    set_req(0, 32'h40000000, 32'h40400000, 1, 1'b1);
    run_until_idle(40);
    check_grants("single_grant", 32'h0, 1);
    check("single_busy_after", 32'(busy), 32'd0);
    want_set = 1'b0;

    // Pointer wrap: serve 3, then 0 and 3 together -> 0 first.
    set_req(3, rand_fp(), rand_fp(), 1, 1'b0);
    run_until_idle(40);
    set_req(0, rand_fp(), rand_fp(), 1, 1'b0);
    set_req(3, rand_fp(), rand_fp(), 1, 1'b0);
    run_until_idle(60);
    check_grants("wrap_order", 32'h303, 3);

    // Contention with all four held.
    set_req(0, rand_fp(), rand_fp(), 2, 1'b0);
    for (int i = 1; i < N; i++) set_req(i, rand_fp(), rand_fp(), 1, 1'b0);
    run_until_idle(120);
    check_grants("contention_order", 32'h03210, 5);

    // Back-to-back on requester 2: -1.5 * 4.0.
    want_set = 1'b1; want_data = 32'hC0C00000;
    set_req(2, 32'hBFC00000, 32'h40800000, 3, 1'b1);
    run_until_idle(80);
    check_grants("b2b_order", 32'h222, 3);
    want_set = 1'b0;

    // Randomized traffic with spurious multiplier pulses outside WAIT.
    rand_mode = 1'b1; mult_noise = 1'b1;
    repeat (400) cycle_step();
    rand_mode = 1'b0;
    run_until_idle(300);
    mult_noise = 1'b0;
    grants.delete();

    // Reset while in WAIT.
    force_lat = 5;
    set_req(0, rand_fp(), rand_fp(), 1, 1'b0);
    n = 0;
    while (!outstanding && n < 10) begin cycle_step(); n++; end
    repeat (3) cycle_step();
    #2 reset_n = 1'b0;
    #1 check_all_zero("midreset");
    sb.delete(); outstanding = 1'b0; issue_due = 1'b0; rr_model = 0; grants.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    force_lat = 0;
    repeat (10) cycle_step();
    set_req(1, rand_fp(), rand_fp(), 1, 1'b0);
    run_until_idle(40);
    check_grants("post_reset", 32'h1, 1);

`ifdef FP_ARB_TIMEOUT_EN
    // Multiplier never answers: quiet NaN with error after TIMEOUT WAIT cycles.
    mult_dead = 1'b1;
    set_req(2, rand_fp(), rand_fp(), 1, 1'b0);
    run_until_idle(40);
    mult_dead = 1'b0;
    set_req(3, rand_fp(), rand_fp(), 1, 1'b0);
    run_until_idle(40);
    check_grants("timeout_order", 32'h32, 2);
`endif

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
